freq_meter: RTL and testbench

// Measures the frequency of an asynchronous square-wave input by counting its rising edges

---
 rtl/freq_meter_if.sv | 20 ++
 rtl/freq_meter.sv | 112 +++++++++++
 tb/tb_freq_meter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_if
// Brief    : Control/result bundle between a frequency meter and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_meter_if #(
   parameter int CNT_W = 32
);
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] freq;
   logic             valid;
   logic             ovf;
   logic             busy;

   modport master (output en, sig_in, input freq, valid, ovf, busy);
   modport slave  (input en, sig_in, output freq, valid, ovf, busy);
endinterface
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Brief    : Counts rising edges of an asynchronous input over a gate window.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 32
) (
   input  wire logic   clk,
   input  wire logic   rst,
   freq_meter_if.slave bus
);
   localparam int               C_GW   = $clog2(GATE_CYCLES);
   localparam logic [C_GW-1:0]  C_LAST = C_GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_MAX  = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GATE  = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_s1, r_s2, r_s3;
   logic             w_edge;
   logic [C_GW-1:0]  r_gate_cnt;
   logic [CNT_W-1:0] r_edge_cnt;
   logic             r_sat;
   logic [CNT_W-1:0] r_freq;
   logic             r_ovf;
   logic             w_last;
   logic             w_count;
   logic             w_close;
   logic             w_sat_now;
   logic [CNT_W-1:0] w_cnt_inc;

   // Synchronizer and edge register run regardless of state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge    = r_s2 & ~r_s3;
   assign w_last    = (r_gate_cnt == C_LAST);
   assign w_count   = (r_state == S_GATE) && bus.en;
   assign w_close   = w_count && w_last;
   assign w_sat_now = w_edge && (r_edge_cnt == C_MAX);
   assign w_cnt_inc = (w_edge && !w_sat_now) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Dropping en during GATE aborts, even on the last gate cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = bus.en ? S_GATE : S_IDLE;
         S_GATE: begin
            if (!bus.en)      w_next = S_IDLE;
            else if (w_last)  w_next = S_LATCH;
            else              w_next = S_GATE;
         end
         S_LATCH: w_next = bus.en ? S_GATE : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !w_count || w_last) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
      end else begin
         r_gate_cnt <= r_gate_cnt + C_GW'(1);
         r_edge_cnt <= w_cnt_inc;
         r_sat      <= r_sat | w_sat_now;
      end
   end

   // The last gate cycle's own edge is folded into the published count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_freq <= '0;
         r_ovf  <= 1'b0;
      end else if (w_close) begin
         r_freq <= w_cnt_inc;
         r_ovf  <= r_sat | w_sat_now;
      end
   end

   always_comb begin
      bus.valid = (r_state == S_LATCH);
      bus.busy  = (r_state == S_GATE);
   end

   assign bus.freq = r_freq;
   assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Brief    : Self-checking bench for freq_meter, 32-bit and 4-bit counters in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;
   localparam int G = 100;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic en     = 1'b0;
   logic sig_in = 1'b0;

   always #5 clk = ~clk;

   freq_meter_if #(.CNT_W(32)) if32 ();
   freq_meter_if #(.CNT_W(4))  if4 ();

   assign if32.en     = en;
   assign if32.sig_in = sig_in;
   assign if4.en      = en;
   assign if4.sig_in  = sig_in;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
   freq_meter #(.GATE_CYCLES(G), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   pat_period = 0;
   int   pat_cnt = 0;
   logic pat_level = 1'b0;
   bit   rnd_sig = 1'b0;

   // Reference: window position -1 idle, 0..G-1 gate, G latch; edges appear
   // when the input sampled two clocks ago is high and three clocks ago was low.
   logic [3:0] m_hist = 4'b0;
   int         m_pos = -1;
   int         m_n = 0;
   int         m_total = 0;
   logic       m_edge;
   logic       m_valid;
   logic       m_busy;

   assign m_edge  = m_hist[1] & ~m_hist[2];
   assign m_valid = (m_pos == G);
   assign m_busy  = (m_pos >= 0) && (m_pos < G);

   always @(posedge clk) begin
      m_hist <= {m_hist[2:0], rst ? 1'b0 : sig_in};
      if (rst) begin
         m_pos <= -1; m_n <= 0; m_total <= 0;
      end else if (m_pos == -1) begin
         if (en) m_pos <= 0;
         m_n <= 0;
      end else if (m_pos == G) begin
         m_pos <= en ? 0 : -1;
         m_n <= 0;
      end else if (!en) begin
         m_pos <= -1; m_n <= 0;
      end else if (m_pos == G - 1) begin
         m_total <= m_n + int'(m_edge);
         m_pos <= G; m_n <= 0;
      end else begin
         m_pos <= m_pos + 1;
         m_n <= m_n + int'(m_edge);
      end
   end

   function automatic int sat4(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic step();
      @(negedge clk);
      cyc++;
      if (rnd_sig)              sig_in = 1'($urandom_range(0, 1));
      else if (pat_period == 0) sig_in = pat_level;
      else begin
         sig_in  = (pat_cnt < pat_period / 2);
         pat_cnt = (pat_cnt + 1) % pat_period;
      end
   endtask

   task automatic wait_valid(output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (if32.valid === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      repeat (3) step();
      checks++; if (if32.freq !== 32'd0) begin failures++; $display("FAIL reset_freq32: got %0d want 0", if32.freq); end
      checks++; if (if32.valid !== 1'b0) begin failures++; $display("FAIL reset_valid32: got %b want 0", if32.valid); end
      checks++; if (if32.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf32: got %b want 0", if32.ovf); end
      checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy32: got %b want 0", if32.busy); end
      checks++; if (if4.freq !== 4'd0) begin failures++; $display("FAIL reset_freq4: got %0d want 0", if4.freq); end
      checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy4: got %b want 0", if4.busy); end
      rst = 1'b0;
   endtask

   task automatic test_continuous();
      int at, prev;
      pat_period = 10; pat_cnt = 0;
      repeat (5) step();
      en = 1'b1;
      prev = -1;
      for (int w = 0; w < 3; w++) begin
         wait_valid(at);
         checks++; if (at < 0) begin failures++; $display("FAIL cont_timeout: got no valid want valid"); end
         checks++; if (if32.freq !== 32'd10) begin failures++; $display("FAIL cont_freq32: got %0d want 10", if32.freq); end
         checks++; if (if4.freq !== 4'd10 || if4.ovf !== 1'b0) begin failures++; $display("FAIL cont_freq4: got %0d/%b want 10/0", if4.freq, if4.ovf); end
         if (prev >= 0) begin
            checks++; if (at - prev != G + 1) begin failures++; $display("FAIL cont_period: got %0d want %0d", at - prev, G + 1); end
         end
         prev = at;
         step();
         checks++; if (if32.valid !== 1'b0 || if32.busy !== 1'b1) begin failures++; $display("FAIL cont_pulse: got valid=%b busy=%b want 0/1", if32.valid, if32.busy); end
      end
   endtask

   task automatic test_constant();
      int at;
      en = 1'b0; pat_period = 0; pat_level = 1'b0;
      repeat (5) step();
      pat_level = 1'b1;
      repeat (10) step();
      en = 1'b1;
      for (int w = 0; w < 2; w++) begin
         wait_valid(at);
         checks++; if (at < 0) begin failures++; $display("FAIL const_timeout: got no valid want valid"); end
         checks++; if (if32.freq !== 32'd0 || if32.ovf !== 1'b0) begin failures++; $display("FAIL const_freq: got %0d/%b want 0/0", if32.freq, if32.ovf); end
      end
   endtask

   task automatic test_saturation();
      int at;
      pat_period = 2; pat_cnt = 0;
      repeat (5) step();
      wait_valid(at);
      wait_valid(at);
      checks++; if (at < 0) begin failures++; $display("FAIL sat_timeout: got no valid want valid"); end
      checks++; if (if4.freq !== 4'd15 || if4.ovf !== 1'b1) begin failures++; $display("FAIL sat_freq4: got %0d/%b want 15/1", if4.freq, if4.ovf); end
      checks++; if (if32.freq !== 32'd50 || if32.ovf !== 1'b0) begin failures++; $display("FAIL sat_freq32: got %0d/%b want 50/0", if32.freq, if32.ovf); end
      pat_period = 20; pat_cnt = 0;
      repeat (5) step();
      wait_valid(at);
      wait_valid(at);
      checks++; if (if4.freq !== 4'd5 || if4.ovf !== 1'b0) begin failures++; $display("FAIL unsat_freq4: got %0d/%b want 5/0", if4.freq, if4.ovf); end
      checks++; if (if32.freq !== 32'd5) begin failures++; $display("FAIL unsat_freq32: got %0d want 5", if32.freq); end
   endtask

   task automatic test_abort();
      int at, r;
      pat_period = 10; pat_cnt = 0;
      repeat (5) step();
      wait_valid(at);
      wait_valid(at);
      checks++; if (if32.freq !== 32'd10) begin failures++; $display("FAIL abort_pre_freq: got %0d want 10", if32.freq); end
      repeat (51) step();
      en = 1'b0;
      step();
      checks++; if (if32.busy !== 1'b0 || if32.valid !== 1'b0) begin failures++; $display("FAIL abort_state: got busy=%b valid=%b want 0/0", if32.busy, if32.valid); end
      checks++; if (if32.freq !== 32'd10) begin failures++; $display("FAIL abort_hold: got %0d want 10", if32.freq); end
      repeat (7) step();
      en = 1'b1; r = cyc;
      wait_valid(at);
      checks++; if (at - r != G + 1) begin failures++; $display("FAIL abort_restart: got %0d want %0d", at - r, G + 1); end
      checks++; if (if32.freq !== 32'd10) begin failures++; $display("FAIL abort_full: got %0d want 10", if32.freq); end
   endtask

   task automatic test_reset_mid();
      int at, r;
      repeat (30) step();
      rst = 1'b1;
      step();
      checks++; if (if32.freq !== 32'd0 || if32.valid !== 1'b0 || if32.ovf !== 1'b0 || if32.busy !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs: got %0d/%b/%b/%b want 0/0/0/0", if32.freq, if32.valid, if32.ovf, if32.busy); end
      checks++; if (if4.freq !== 4'd0 || if4.ovf !== 1'b0) begin failures++; $display("FAIL midrst_out4: got %0d/%b want 0/0", if4.freq, if4.ovf); end
      rst = 1'b0; r = cyc;
      wait_valid(at);
      checks++; if (at - r != G + 1) begin failures++; $display("FAIL midrst_window: got %0d want %0d", at - r, G + 1); end
   endtask

   task automatic test_boundary();
      int v0;
      pat_period = 0; pat_level = 1'b0;
      wait_valid(v0);
      repeat (G - 1) step();
      pat_level = 1'b1; sig_in = 1'b1;
      repeat (2) step();
      checks++; if (if32.valid !== 1'b1 || if32.freq !== 32'd0) begin failures++; $display("FAIL latch_edge_pre: got valid=%b freq=%0d want 1/0", if32.valid, if32.freq); end
      repeat (50) step();
      pat_level = 1'b0; sig_in = 1'b0;
      repeat (48) step();
      pat_level = 1'b1; sig_in = 1'b1;
      repeat (3) step();
      checks++; if (if32.valid !== 1'b1 || if32.freq !== 32'd1) begin failures++; $display("FAIL last_gate_edge: got valid=%b freq=%0d want 1/1", if32.valid, if32.freq); end
      checks++; if (if4.freq !== 4'd1) begin failures++; $display("FAIL last_gate_edge4: got %0d want 1", if4.freq); end
   endtask

   task automatic test_random();
      rnd_sig = 1'b1;
      for (int i = 0; i < 900; i++) begin
         step();
         checks++; if (if32.valid !== m_valid || if4.valid !== m_valid) begin failures++; $display("FAIL rnd_valid: got %b/%b want %b", if32.valid, if4.valid, m_valid); end
         checks++; if (if32.busy !== m_busy || if4.busy !== m_busy) begin failures++; $display("FAIL rnd_busy: got %b/%b want %b", if32.busy, if4.busy, m_busy); end
         checks++; if (if32.freq !== 32'(m_total) || if32.ovf !== 1'b0) begin failures++; $display("FAIL rnd_freq32: got %0d/%b want %0d/0", if32.freq, if32.ovf, m_total); end
         checks++; if (if4.freq !== 4'(sat4(m_total)) || if4.ovf !== (m_total > 15)) begin
            failures++; $display("FAIL rnd_freq4: got %0d/%b want %0d/%b", if4.freq, if4.ovf, sat4(m_total), (m_total > 15)); end
         if ($urandom_range(0, 249) == 0)            en = 1'b0;
         else if (!en && $urandom_range(0, 3) == 0)  en = 1'b1;
      end
      rnd_sig = 1'b0;
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_constant();
      test_saturation();
      test_abort();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
